// File: rtl/wb_ram_responder_if.sv
// Wishbone bus bundle shared by the bexkat2 core and its responders.
// stb is qualified with cyc at the responder.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic [31:0] adr;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;

  modport master (
    output cyc, stb, adr, we, sel, dat_m,
    input  dat_s, ack
  );

  modport slave (
    input  cyc, stb, adr, we, sel, dat_m,
    output dat_s, ack
  );
endinterface

// File: rtl/wb_ram_responder.sv
// Word-organised Wishbone RAM responder.
// Byte-lane writes, programmable wait states, single-cycle ack.
module wb_ram_responder #(
  parameter int    AW          = 10,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input logic clk_i,
  input logic rst_i,
  if_wb.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_chk
    $error("wb_ram_responder: WAIT_STATES must be 0..15");
  end

  logic [31:0] mem [2**AW];

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   wdat_q, wdat_d;
  logic [31:0]   dat_s_q, dat_s_d;

  logic          req;
  logic          go;
  logic [AW-1:0] acc_adr;
  logic          acc_we;
  logic [3:0]    acc_sel;
  logic [31:0]   acc_dat;
  logic          unused_adr;

  assign req        = bus.cyc & bus.stb;
  assign unused_adr = ^{bus.adr[31:AW+2], bus.adr[1:0]};

  // go marks the edge entering ACK; with no wait states the
  // access uses the live bus fields instead of the latched ones
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    go      = 1'b0;
    acc_adr = adr_q;
    acc_we  = we_q;
    acc_sel = sel_q;
    acc_dat = wdat_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          adr_d   = bus.adr[AW+1:2];
          we_d    = bus.we;
          sel_d   = bus.sel;
          wdat_d  = bus.dat_m;
          acc_adr = bus.adr[AW+1:2];
          acc_we  = bus.we;
          acc_sel = bus.sel;
          acc_dat = bus.dat_m;
          if (WAIT_STATES == 0) begin
            state_d = ACK;
            go      = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (!bus.cyc) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
          go      = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dat_s_d = dat_s_q;
    if (go && !acc_we) dat_s_d = mem[acc_adr];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      wdat_q  <= 32'h0;
      dat_s_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      dat_s_q <= dat_s_d;
    end
  end

  // RAM is never cleared; a write held under reset is dropped
  always_ff @(posedge clk_i) begin
    if (!rst_i && go && acc_we) begin
      for (int n = 0; n < 4; n++) begin
        if (acc_sel[n]) mem[acc_adr][8*n +: 8] <= acc_dat[8*n +: 8];
      end
    end
  end

  assign bus.ack   = (state_q == ACK);
  assign bus.dat_s = dat_s_q;

endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed bench for wb_ram_responder: zero/three wait states,
// byte lanes, abort, address aliasing and async reset.
module tb_wb_ram_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cyc [3];
  logic        we  [3];
  logic [31:0] adr [3];
  logic [3:0]  sel [3];
  logic [31:0] dm  [3];
  logic        ack [3];
  logic [31:0] ds  [3];

  int nvec = 0;
  int nerr = 0;

  if_wb w0 ();
  if_wb w3 ();
  if_wb wa ();

  assign w0.cyc = cyc[0]; assign w0.stb = cyc[0];
  assign w0.we  = we[0];  assign w0.adr = adr[0];
  assign w0.sel = sel[0]; assign w0.dat_m = dm[0];
  assign ack[0] = w0.ack; assign ds[0] = w0.dat_s;

  assign w3.cyc = cyc[1]; assign w3.stb = cyc[1];
  assign w3.we  = we[1];  assign w3.adr = adr[1];
  assign w3.sel = sel[1]; assign w3.dat_m = dm[1];
  assign ack[1] = w3.ack; assign ds[1] = w3.dat_s;

  assign wa.cyc = cyc[2]; assign wa.stb = cyc[2];
  assign wa.we  = we[2];  assign wa.adr = adr[2];
  assign wa.sel = sel[2]; assign wa.dat_m = dm[2];
  assign ack[2] = wa.ack; assign ds[2] = wa.dat_s;

  wb_ram_responder #(.AW(10), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst), .bus(w0.slave));
  wb_ram_responder #(.AW(10), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_i(rst), .bus(w3.slave));
  wb_ram_responder #(.AW(4), .WAIT_STATES(0)) u_aw4 (
    .clk_i(clk), .rst_i(rst), .bus(wa.slave));

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_bus(int k, logic c, logic w, logic [31:0] a,
                         logic [3:0] s, logic [31:0] d);
    cyc[k] = c; we[k] = w; adr[k] = a; sel[k] = s; dm[k] = d;
  endtask

  // Called at a negedge with the responder idle; returns read data.
  task automatic xfer(string tag, int k, logic w, logic [31:0] a,
                      logic [3:0] s, logic [31:0] d, int ws,
                      output logic [31:0] rd);
    int lat;
    lat = -1;
    rd  = 32'hx;
    set_bus(k, 1'b1, w, a, s, d);
    @(posedge clk);
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (ack[k] === 1'b1) begin
        lat = i;
        rd  = ds[k];
        break;
      end
    end
    cyc[k] = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(ws));
    @(negedge clk);
    check({tag, "_ackw"}, {31'd0, ack[k]}, 32'd0);
  endtask

  logic [31:0] rd;
  int          nack;

  initial begin
    for (int k = 0; k < 3; k++) set_bus(k, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_ack%0d", k), {31'd0, ack[k]}, 32'd0);
      check($sformatf("rst_dat%0d", k), ds[k], 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    xfer("t1_wr", 0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, rd);
    check("t1_wr_dats", ds[0], 32'h0);
    xfer("t1_rd", 0, 1'b0, 32'h10, 4'h1, 32'h0, 0, rd);
    check("t1_rd_dat", rd, 32'hDEADBEEF);

    xfer("t2_pre", 0, 1'b1, 32'h20, 4'hF, 32'h11223344, 0, rd);
    xfer("t2_w4", 0, 1'b1, 32'h20, 4'b0100, 32'h00AA0000, 0, rd);
    xfer("t2_r4", 0, 1'b0, 32'h20, 4'h0, 32'h0, 0, rd);
    check("t2_r4_dat", rd, 32'h11AA3344);
    xfer("t2_w3", 0, 1'b1, 32'h20, 4'b0011, 32'h0000BEEF, 0, rd);
    xfer("t2_r3", 0, 1'b0, 32'h22, 4'hF, 32'h0, 0, rd);
    check("t2_r3_dat", rd, 32'h11AABEEF);
    xfer("t2_w0", 0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 0, rd);
    xfer("t2_r0", 0, 1'b0, 32'h20, 4'hF, 32'h0, 0, rd);
    check("t2_r0_dat", rd, 32'h11AABEEF);

    xfer("t3_wr", 1, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 3, rd);
    xfer("t3_rd", 1, 1'b0, 32'h30, 4'hF, 32'h0, 3, rd);
    check("t3_rd_dat", rd, 32'hCAFEF00D);

    set_bus(1, 1'b1, 1'b1, 32'h30, 4'hF, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    cyc[1] = 1'b0;
    nack = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack[1] === 1'b1) nack++;
    end
    check("t4_noack", 32'(nack), 32'd0);
    xfer("t4_rd", 1, 1'b0, 32'h30, 4'hF, 32'h0, 3, rd);
    check("t4_rd_dat", rd, 32'hCAFEF00D);

    xfer("t5_wr", 2, 1'b1, 32'h40, 4'hF, 32'hA5A55A5A, 0, rd);
    xfer("t5_rd", 2, 1'b0, 32'h00, 4'hF, 32'h0, 0, rd);
    check("t5_rd_dat", rd, 32'hA5A55A5A);
    xfer("t5_wr2", 2, 1'b1, 32'hFFFF_FFC4, 4'hF, 32'h0BADF00D, 0, rd);
    xfer("t5_rd2", 2, 1'b0, 32'h04, 4'hF, 32'h0, 0, rd);
    check("t5_rd2_dat", rd, 32'h0BADF00D);

    xfer("t6_pre", 1, 1'b1, 32'h34, 4'hF, 32'h11111111, 3, rd);
    set_bus(1, 1'b1, 1'b1, 32'h34, 4'hF, 32'h22222222);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_ack", {31'd0, ack[1]}, 32'd0);
    check("t6_dats", ds[1], 32'h0);
    nack = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack[1] === 1'b1) nack++;
    end
    check("t6_noack", 32'(nack), 32'd0);
    cyc[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    xfer("t6_rd", 1, 1'b0, 32'h34, 4'hF, 32'h0, 3, rd);
    check("t6_rd_dat", rd, 32'h11111111);

    set_bus(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("t7_ack_on", {31'd0, ack[0]}, 32'd1);
    check("t7_dat", ds[0], 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    check("t7_ack_drop", {31'd0, ack[0]}, 32'd0);
    check("t7_dats", ds[0], 32'h0);
    cyc[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
